instr_cycle_sequencer: RTL
==========================

Name: instr_cycle_sequencer

Overview:
Multi-cycle control FSM for the KGP RISC datapath when instruction and data memory share one single-port memory. It sequences fetch, decode, execute, memory and writeback, and arbitrates the shared memory port between instruction fetch (address = PC) and load/store (address = ALU result). It generates PC, IR and register-file write enables from the decoded control lines.

Parameters:
WAIT_LIMIT, 16, max cycles mem_req may stay high without mem_ack before fault; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must hold WAIT_LIMIT.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
start  input  1  leave IDLE and begin fetching
pc  input  32  current PC from Program_Counter
alu_out  input  32  load/store address from ALU
store_data  input  32  read_2 value to be stored
ctl_mem_read  input  1  main_control Memread
ctl_mem_write  input  1  main_control Memwrite
ctl_reg_write  input  1  main_control reg_write
ctl_halt  input  1  decoded halt opcode
mem_rdata  input  32  shared memory read data
mem_ack  input  1  memory completes the current request
mem_req  output  1  request to shared memory
mem_we  output  1  write strobe qualifying mem_req
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
ir_out  output  32  latched instruction
mdr_out  output  32  latched load data
pc_en  output  1  one-cycle PC update enable
rf_we  output  1  one-cycle register-file write enable
busy  output  1  high in any state except IDLE/HALT/FAULT
halted  output  1  HALT state
fault  output  1  FAULT state (memory timeout)
state_out  output  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 FAULT=7

Behaviour:
- Reset (rst=0 at edge): state IDLE; all outputs 0, including ir_out, mdr_out and the wait counter. Reset mid-operation aborts immediately; mem_req is 0 from the next edge.
- IDLE: start=1 -> FETCH. start is ignored in all other states.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - mem_ack=1: ir_out<=mem_rdata at that edge; next state DECODE.
  - A zero-wait ack in the first FETCH cycle is legal.
- DECODE: one cycle (register-file read settles) -> EXEC.
- EXEC: one cycle; ctl_* sampled here. Priority:
  - ctl_halt -> HALT
  - else ctl_mem_read or ctl_mem_write -> MEM
  - else -> WB
- MEM: mem_req=1, mem_addr=alu_out, mem_we=ctl_mem_write, mem_wdata=store_data.
  - If both read and write are set, the write wins and mdr_out is not updated.
  - On mem_ack: a read latches mdr_out<=mem_rdata; next state WB.
- WB: one cycle; rf_we=ctl_reg_write; pc_en=1; next state FETCH.
- Outside FETCH/MEM: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. mem_ack is ignored when mem_req=0.
- Minimum latency: ALU/branch instruction 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles. Each ack wait cycle adds 1.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each request cycle without ack.
  - When it reaches WAIT_LIMIT with still no ack -> FAULT. A timeout condition and mem_ack in the same cycle: ack wins.
  - FAULT: fault=1, mem_req=0; held until reset.
- HALT: halted=1, pc_en=0, rf_we=0; held until reset.
- busy=1 in FETCH, DECODE, EXEC, MEM, WB.
- ir_out and mdr_out hold their value between updates.

Optional Feature:
RETIRE_CNT_EN
- Defined: adds output retired_count[31:0], reset 0, incremented by 1 in every WB cycle, wraps 0xFFFFFFFF -> 0. HALT does not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ALU instr, reset release, start=1, zero-wait ack, mem_rdata=0x00221820 -> state 1,2,3,5 on consecutive cycles; ir_out=0x00221820; rf_we=pc_en=1 only in WB; back in FETCH on cycle 5.
- Load, alu_out=0x10, ack 3 cycles after MEM entry, mem_rdata=0xDEADBEEF -> mem_addr=0x10, mem_we=0 for 3 cycles; mdr_out=0xDEADBEEF; rf_we=1 in WB.
- Store, ctl_mem_write=1, ctl_reg_write=0, store_data=0x12345678 -> mem_we=1, mem_wdata=0x12345678 while in MEM; rf_we=0, pc_en=1 in WB; mdr_out unchanged.
- WAIT_LIMIT=8, no ack in FETCH -> mem_req high for exactly 8 cycles, then fault=1, state_out=7, mem_req=0; start ignored until rst=0.
- ctl_halt=1 in EXEC -> halted=1, busy=0, no further mem_req; start pulse ignored; rst=0 returns IDLE with all outputs 0.
- rst=0 during a MEM wait with mem_we=1 -> mem_req and mem_we 0 after the edge; state IDLE; with RETIRE_CNT_EN, retired_count=0 and 3 completed instructions after restart give retired_count=3.

Source files
------------

// File: rtl/instr_cycle_sequencer_if.sv
// Shared single-port memory bus used by instr_cycle_sequencer.
//   master (sequencer) : drives mem_req, mem_we, mem_addr, mem_wdata;
//                        receives mem_rdata, mem_ack
//   slave  (memory)    : the mirror image of master
interface instr_cycle_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/instr_cycle_sequencer.sv
// Multi-cycle control FSM for the KGP RISC datapath with one shared
// single-port memory. It walks FETCH -> DECODE -> EXEC -> [MEM] -> WB and
// hands the memory port to instruction fetch (address = pc) or to the
// load/store (address = alu_out). A request left unacknowledged for
// WAIT_LIMIT cycles parks the FSM in FAULT until reset.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   start           leave IDLE and begin fetching
//   pc, alu_out     fetch address, load/store address
//   store_data      data written on a store
//   ctl_*           decoded control lines, sampled in EXEC/MEM/WB
//   mem             shared memory bus (master side)
//   ir_out, mdr_out latched instruction and load data
//   pc_en, rf_we    one-cycle enables issued in WB
//   busy, halted, fault, state_out   status
//
// Optional feature (macro RETIRE_CNT_EN): adds retired_count[31:0], counting
// WB cycles.
module instr_cycle_sequencer #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic        ctl_mem_read,
  input  logic        ctl_mem_write,
  input  logic        ctl_reg_write,
  input  logic        ctl_halt,
  instr_cycle_sequencer_if.master mem,
  output logic [31:0] ir_out,
  output logic [31:0] mdr_out,
  output logic        pc_en,
  output logic        rf_we,
  output logic        busy,
  output logic        halted,
  output logic        fault,
`ifdef RETIRE_CNT_EN
  output logic [31:0] retired_count,
`endif
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    FAULT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout;
  logic             in_req;

  assign in_req = (state == FETCH) || (state == MEM);

  // The counter holds the number of un-acked request cycles already spent;
  // the current un-acked cycle is the WAIT_LIMIT-th when it reads LIMIT_M1.
  assign timeout = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT_M1);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt           = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'h0;
    mem.mem_wdata = 32'h0;
    pc_en         = 1'b0;
    rf_we         = 1'b0;
    case (state)
      IDLE: if (start) nxt = FETCH;
      FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc;
        if (mem.mem_ack)  nxt = DECODE;
        else if (timeout) nxt = FAULT;
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        if (ctl_halt)                          nxt = HALT;
        else if (ctl_mem_read || ctl_mem_write) nxt = MEM;
        else                                   nxt = WB;
      end
      MEM: begin
        mem.mem_req   = 1'b1;
        mem.mem_addr  = alu_out;
        mem.mem_we    = ctl_mem_write;
        mem.mem_wdata = store_data;
        if (mem.mem_ack)  nxt = WB;
        else if (timeout) nxt = FAULT;
      end
      WB: begin
        rf_we = ctl_reg_write;
        pc_en = 1'b1;
        nxt   = FETCH;
      end
      HALT:    nxt = HALT;
      FAULT:   nxt = FAULT;
      default: nxt = IDLE;
    endcase
  end

  // Instruction/load latches and the request wait counter. A simultaneous
  // read+write is treated as a store, so mdr_out is left alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_out   <= 32'h0;
      mdr_out  <= 32'h0;
      wait_cnt <= '0;
    end else begin
      if (state == FETCH && mem.mem_ack)
        ir_out <= mem.mem_rdata;
      if (state == MEM && mem.mem_ack && ctl_mem_read && !ctl_mem_write)
        mdr_out <= mem.mem_rdata;
      // FETCH and MEM are always entered from a non-request state, so
      // clearing outside them restarts the count on every new request.
      if (in_req && !mem.mem_ack) wait_cnt <= wait_cnt + CNT_W'(1);
      else                        wait_cnt <= '0;
    end
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)             retired_count <= 32'h0;
    else if (state == WB) retired_count <= retired_count + 32'd1;
  end
`endif

  assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                     (state == MEM)   || (state == WB);
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);
  assign state_out = state;

endmodule
